// File: rtl/clk_pkg.sv
// Shared constants and output bundles for the divided-clock generator.
// The default clock rates and the small simulation rates live here.
package clk_pkg;

  localparam int DEFAULT_CLK_HZ  = 100_000_000;
  localparam int DEFAULT_FAST_HZ = 500;
  localparam int SIM_CLK_HZ      = 16;
  localparam int SIM_FAST_HZ     = 4;

  // Outputs derived from the one-second chain; cleared together by clr.
  typedef struct packed {
    logic onehz_clock;
    logic twohz_clock;
    logic one_tick;
    logic two_tick;
  } slow_out_t;

  // Display-refresh outputs; only reset affects them.
  typedef struct packed {
    logic fast_clock;
    logic fast_tick;
  } fast_out_t;

  localparam slow_out_t SLOW_IDLE = '0;
  localparam fast_out_t FAST_IDLE = '0;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear and enable.
// wrap flags the terminal count so the caller can see the roll-over cycle.
module mod_counter
  import clk_pkg::*;
#(
  parameter int MOD = 4,
  localparam int W = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  assign wrap  = (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Divides the board clock into 1 Hz / 2 Hz square waves with ticks and a display-refresh wave.
// Every output is a flop fed by the decode of the counter value present before the edge.
module clk_div_gen
  import clk_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int FAST_HZ = DEFAULT_FAST_HZ
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic onehz_clock,
  output logic twohz_clock,
  output logic one_tick,
  output logic two_tick,
  output logic fast_clock,
  output logic fast_tick
);

  localparam int FDIV = CLK_HZ / FAST_HZ;
  localparam int SC_W = $clog2(CLK_HZ);
  localparam int FC_W = (FDIV > 1) ? $clog2(FDIV) : 1;

  localparam logic [SC_W-1:0] Q_C  = SC_W'(CLK_HZ / 4);
  localparam logic [SC_W-1:0] H_C  = SC_W'(CLK_HZ / 2);
  localparam logic [SC_W-1:0] HQ_C = SC_W'(CLK_HZ / 2 + CLK_HZ / 4);
  localparam logic [FC_W-1:0] FH_C = FC_W'(FDIV / 2);

  logic [SC_W-1:0] sc;
  logic [FC_W-1:0] fc;
  logic            sc_wrap;
  logic            fc_wrap;
  logic            unused_wraps;

  slow_out_t slow_d, slow_q;
  fast_out_t fast_d, fast_q;

  mod_counter #(.MOD(CLK_HZ)) u_sec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (1'b1),
    .count (sc),
    .wrap  (sc_wrap)
  );

  // The refresh chain never restarts on clr so the display keeps scanning.
  mod_counter #(.MOD(FDIV)) u_fast_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (1'b1),
    .count (fc),
    .wrap  (fc_wrap)
  );

  assign unused_wraps = sc_wrap ^ fc_wrap;

  always_comb begin
    slow_d = SLOW_IDLE;
    if (!clr) begin
      slow_d.onehz_clock = (sc < H_C);
      // Both halves of the second start a 2 Hz high phase, keeping rising edges aligned with 1 Hz.
      slow_d.twohz_clock = (sc < Q_C) || ((sc >= H_C) && (sc < HQ_C));
      slow_d.one_tick    = (sc == '0);
      slow_d.two_tick    = (sc == '0) || (sc == H_C);
    end
    fast_d.fast_clock = (fc < FH_C);
    fast_d.fast_tick  = (fc == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slow_q <= SLOW_IDLE;
      fast_q <= FAST_IDLE;
    end else begin
      slow_q <= slow_d;
      fast_q <= fast_d;
    end
  end

  assign onehz_clock = slow_q.onehz_clock;
  assign twohz_clock = slow_q.twohz_clock;
  assign one_tick    = slow_q.one_tick;
  assign two_tick    = slow_q.two_tick;
  assign fast_clock  = fast_q.fast_clock;
  assign fast_tick   = fast_q.fast_tick;

endmodule
